// File: rtl/inst_mem_arbiter.sv
// Arbitrates one synchronous instruction memory between the CPU fetch port and the programming port.
// One access per 3 cycles (IDLE->ACCESS->RESP); INST_ARB_ROUND_ROBIN_EN swaps fixed prog priority for round-robin.
module inst_mem_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_fetch_req,
   input  logic [ADDR_W-1:0] i_fetch_addr,
   output logic              o_fetch_ack,
   output logic [DATA_W-1:0] o_fetch_rdata,
   input  logic              i_prog_mode,
   input  logic              i_prog_req,
   input  logic              i_prog_we,
   input  logic [ADDR_W-1:0] i_prog_addr,
   input  logic [7:0]        i_prog_wdata,
   output logic              o_prog_ack,
   output logic [DATA_W-1:0] o_prog_rdata,
   output logic              o_mem_en,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [3:0]        o_mem_be,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic              o_busy,
   output logic [7:0]        o_conflicts
);

   localparam int LANE_W = DATA_W / 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   typedef enum logic {
      OWN_FETCH = 1'b0,
      OWN_PROG  = 1'b1
   } owner_t;

   state_t state;
   state_t state_nxt;
   owner_t owner;
   owner_t grant;

   logic fetch_elig;
   logic prog_elig;
   logic grant_vld;
   logic contend;
   logic start;
   logic prog_write;

   logic [DATA_W-1:0] wdata_rep;
   logic [3:0]        be_onehot;
   logic [ADDR_W-1:0] fetch_word_addr;
   logic [ADDR_W-1:0] prog_word_addr;

   // The fetch byte offset is irrelevant: the memory only returns whole words.
   logic unused_fetch_offset;
   assign unused_fetch_offset = ^i_fetch_addr[1:0];

   assign fetch_elig = i_fetch_req & ~i_prog_mode;
   assign prog_elig  = i_prog_req;
   assign grant_vld  = fetch_elig | prog_elig;
   assign contend    = (state == IDLE) & fetch_elig & prog_elig;
   assign start      = (state == IDLE) & grant_vld;
   assign prog_write = (grant == OWN_PROG) & i_prog_we;

   assign fetch_word_addr = {i_fetch_addr[ADDR_W-1:2], 2'b00};
   assign prog_word_addr  = {i_prog_addr[ADDR_W-1:2], 2'b00};
   assign be_onehot       = 4'b0001 << i_prog_addr[1:0];

   always_comb begin
      wdata_rep = '0;
      for (int lane = 0; lane < 4; lane++) begin
         wdata_rep[lane*LANE_W +: LANE_W] = LANE_W'(i_prog_wdata);
      end
   end

`ifdef INST_ARB_ROUND_ROBIN_EN
   owner_t last_grant;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         last_grant <= OWN_FETCH;
      end else if (start) begin
         last_grant <= grant;
      end
   end

   // On contention the side that did not win last time takes the slot.
   always_comb begin
      grant = OWN_FETCH;
      if (contend) begin
         grant = (last_grant == OWN_FETCH) ? OWN_PROG : OWN_FETCH;
      end else if (prog_elig) begin
         grant = OWN_PROG;
      end
   end
`else
   always_comb begin
      grant = prog_elig ? OWN_PROG : OWN_FETCH;
   end
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = grant_vld ? ACCESS : IDLE;
         ACCESS:  state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      o_busy        = (state != IDLE);
      o_fetch_ack   = (state == RESP) & (owner == OWN_FETCH);
      o_prog_ack    = (state == RESP) & (owner == OWN_PROG);
      o_fetch_rdata = o_fetch_ack ? i_mem_rdata : '0;
      o_prog_rdata  = o_prog_ack ? i_mem_rdata : '0;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         owner <= OWN_FETCH;
      end else if (start) begin
         owner <= grant;
      end
   end

   // Strobes are high for exactly the ACCESS cycle; address/data hold until the next grant.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_mem_en    <= 1'b0;
         o_mem_we    <= 1'b0;
         o_mem_be    <= 4'b0000;
         o_mem_addr  <= '0;
         o_mem_wdata <= '0;
      end else if (start) begin
         o_mem_en    <= 1'b1;
         o_mem_we    <= prog_write;
         o_mem_be    <= prog_write ? be_onehot : 4'b0000;
         o_mem_addr  <= (grant == OWN_PROG) ? prog_word_addr : fetch_word_addr;
         o_mem_wdata <= prog_write ? wdata_rep : '0;
      end else if (state == ACCESS) begin
         o_mem_en <= 1'b0;
         o_mem_we <= 1'b0;
         o_mem_be <= 4'b0000;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_conflicts <= 8'd0;
      end else if (contend && (o_conflicts != 8'hFF)) begin
         o_conflicts <= o_conflicts + 8'd1;
      end
   end

endmodule

// File: tb/tb_inst_mem_arbiter.sv
// Scoreboard bench for inst_mem_arbiter: random and directed fetch/prog traffic against a byte-array memory model.
`timescale 1ns/1ps
module tb_inst_mem_arbiter;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_fetch_req;
   logic [7:0]  i_fetch_addr;
   logic        o_fetch_ack;
   logic [31:0] o_fetch_rdata;
   logic        i_prog_mode;
   logic        i_prog_req;
   logic        i_prog_we;
   logic [7:0]  i_prog_addr;
   logic [7:0]  i_prog_wdata;
   logic        o_prog_ack;
   logic [31:0] o_prog_rdata;
   logic        o_mem_en;
   logic        o_mem_we;
   logic [7:0]  o_mem_addr;
   logic [3:0]  o_mem_be;
   logic [31:0] o_mem_wdata;
   logic [31:0] i_mem_rdata;
   logic        o_busy;
   logic [7:0]  o_conflicts;

   inst_mem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_fetch_req(i_fetch_req), .i_fetch_addr(i_fetch_addr),
      .o_fetch_ack(o_fetch_ack), .o_fetch_rdata(o_fetch_rdata),
      .i_prog_mode(i_prog_mode), .i_prog_req(i_prog_req), .i_prog_we(i_prog_we),
      .i_prog_addr(i_prog_addr), .i_prog_wdata(i_prog_wdata),
      .o_prog_ack(o_prog_ack), .o_prog_rdata(o_prog_rdata),
      .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
      .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata),
      .o_busy(o_busy), .o_conflicts(o_conflicts)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [7:0]  addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      bit          chk_wd;
   } mem_exp_t;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] preload [256];
   logic [7:0] mem_b   [256];
   logic [7:0] shadow  [256];
   logic       mem_init;

   logic [31:0] exp_fetch [$];
   logic [31:0] exp_prog  [$];
   bit          exp_order [$];   // 1 = prog ack expected next, 0 = fetch
   mem_exp_t    exp_mem   [$];

   int exp_conf   = 0;
   bit m_last_prog = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] align(input logic [7:0] a);
      return {a[7:2], 2'b00};
   endfunction

   function automatic logic [31:0] sh_word(input logic [7:0] a);
      logic [7:0] w;
      w = align(a);
      return {shadow[w + 8'd3], shadow[w + 8'd2], shadow[w + 8'd1], shadow[w]};
   endfunction

   // Synchronous memory: read-before-write, data one cycle after an enabled edge.
   always @(posedge i_clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem_b[i] <= preload[i];
      end else if (o_mem_en) begin
         i_mem_rdata <= {mem_b[{o_mem_addr[7:2], 2'd3}], mem_b[{o_mem_addr[7:2], 2'd2}],
                         mem_b[{o_mem_addr[7:2], 2'd1}], mem_b[{o_mem_addr[7:2], 2'd0}]};
         if (o_mem_we) begin
            for (int l = 0; l < 4; l++)
               if (o_mem_be[l]) mem_b[{o_mem_addr[7:2], 2'(l)}] <= o_mem_wdata[l*8 +: 8];
         end
      end
   end

   always @(negedge i_clk) begin
      if (!i_rst && !mem_init) begin
         if (o_fetch_ack && o_prog_ack) chk("dual_ack", 32'd1, 32'd0);
         if (o_fetch_ack || o_prog_ack) begin
            if (exp_order.size() == 0) chk("unexpected_ack", 32'd1, 32'd0);
            else chk("ack_owner", {31'd0, o_prog_ack}, {31'd0, exp_order.pop_front()});
         end
         if (o_fetch_ack) begin
            if (exp_fetch.size() == 0) chk("fetch_unexp", 32'd1, 32'd0);
            else chk("fetch_rdata", o_fetch_rdata, exp_fetch.pop_front());
         end else begin
            chk("fetch_rdata_idle", o_fetch_rdata, 32'd0);
         end
         if (o_prog_ack) begin
            if (exp_prog.size() == 0) chk("prog_unexp", 32'd1, 32'd0);
            else chk("prog_rdata", o_prog_rdata, exp_prog.pop_front());
         end else begin
            chk("prog_rdata_idle", o_prog_rdata, 32'd0);
         end
         if (o_mem_en) begin
            if (exp_mem.size() == 0) chk("mem_unexp", 32'd1, 32'd0);
            else begin
               mem_exp_t e;
               e = exp_mem.pop_front();
               chk("mem_addr", {24'd0, o_mem_addr}, {24'd0, e.addr});
               chk("mem_we", {31'd0, o_mem_we}, {31'd0, e.we});
               chk("mem_be", {28'd0, o_mem_be}, {28'd0, e.be});
               if (e.chk_wd) chk("mem_wdata", o_mem_wdata, e.wdata);
            end
         end
      end
   end

   task automatic push_mem(input logic [7:0] a, input logic we, input logic [3:0] be,
                           input logic [31:0] wd, input bit cw);
      mem_exp_t e;
      e.addr = align(a); e.we = we; e.be = be; e.wdata = wd; e.chk_wd = cw;
      exp_mem.push_back(e);
   endtask

   // mode 0: plain, 1: scramble address during ACCESS, 2: raise prog_mode during ACCESS
   task automatic fetch_op(input logic [7:0] addr, input int mode);
      int k;
      bit got;
      exp_fetch.push_back(sh_word(addr));
      push_mem(addr, 1'b0, 4'b0000, 32'd0, 1'b0);
      exp_order.push_back(1'b0);
      m_last_prog = 1'b0;
      i_fetch_addr = addr;
      i_fetch_req  = 1'b1;
      k = 0; got = 1'b0;
      while (k < 20 && !got) begin
         @(negedge i_clk); k++;
         if (o_fetch_ack) got = 1'b1;
         else if (k == 1 && mode == 1) i_fetch_addr = 8'($urandom);
         else if (k == 1 && mode == 2) i_prog_mode = 1'b1;
      end
      i_fetch_req = 1'b0;
      i_prog_mode = 1'b0;
      chk("fetch_ack_seen", {31'd0, got}, 32'd1);
      if (got) chk("fetch_latency", k, 2);
   endtask

   task automatic prog_op(input logic we, input logic [7:0] addr, input logic [7:0] wd);
      int k;
      bit got;
      exp_prog.push_back(sh_word(addr));
      if (we) begin
         push_mem(addr, 1'b1, 4'b0001 << addr[1:0], {4{wd}}, 1'b1);
         shadow[addr] = wd;
      end else begin
         push_mem(addr, 1'b0, 4'b0000, 32'd0, 1'b0);
      end
      exp_order.push_back(1'b1);
      m_last_prog = 1'b1;
      i_prog_addr = addr; i_prog_we = we; i_prog_wdata = wd; i_prog_req = 1'b1;
      k = 0; got = 1'b0;
      while (k < 20 && !got) begin
         @(negedge i_clk); k++;
         if (o_prog_ack) got = 1'b1;
      end
      i_prog_req = 1'b0;
      chk("prog_ack_seen", {31'd0, got}, 32'd1);
      if (got) chk("prog_latency", k, 2);
   endtask

   task automatic idle_gap(input int extra);
      @(negedge i_clk);
      chk("idle_busy", {31'd0, o_busy}, 32'd0);
      repeat (extra) @(negedge i_clk);
   endtask

   // Both sides keep requesting back-to-back; expected grant order comes from a pending-count model.
   task automatic contention(input int np, input int nf);
      logic [7:0] pa [$];
      logic [7:0] fa [$];
      int rp, rf, ip, ifx, bound;
      bit p;
      for (int i = 0; i < np; i++) begin
         pa.push_back(8'($urandom)); exp_prog.push_back(sh_word(pa[i]));
      end
      for (int i = 0; i < nf; i++) begin
         fa.push_back(8'($urandom)); exp_fetch.push_back(sh_word(fa[i]));
      end
      rp = np; rf = nf; ip = 0; ifx = 0;
      while (rp > 0 || rf > 0) begin
         if (rp > 0 && rf > 0) begin
            if (exp_conf < 255) exp_conf++;
`ifdef INST_ARB_ROUND_ROBIN_EN
            p = !m_last_prog;
`else
            p = 1'b1;
`endif
         end else begin
            p = (rp > 0);
         end
         m_last_prog = p;
         exp_order.push_back(p);
         if (p) begin push_mem(pa[ip], 1'b0, 4'b0000, 32'd0, 1'b0); ip++; rp--; end
         else   begin push_mem(fa[ifx], 1'b0, 4'b0000, 32'd0, 1'b0); ifx++; rf--; end
      end
      bound = 3 * (np + nf) + 10;
      fork
         begin
            int k;
            bit ok;
            ok = 1'b1;
            for (int i = 0; i < np && ok; i++) begin
               i_prog_addr = pa[i]; i_prog_we = 1'b0; i_prog_req = 1'b1;
               k = 0;
               do begin @(negedge i_clk); k++; end while (!o_prog_ack && k < bound);
               if (!o_prog_ack) begin ok = 1'b0; chk("cont_prog_timeout", 32'd1, 32'd0); end
            end
            i_prog_req = 1'b0;
         end
         begin
            int k;
            bit ok;
            ok = 1'b1;
            for (int i = 0; i < nf && ok; i++) begin
               i_fetch_addr = fa[i]; i_fetch_req = 1'b1;
               k = 0;
               do begin @(negedge i_clk); k++; end while (!o_fetch_ack && k < bound);
               if (!o_fetch_ack) begin ok = 1'b0; chk("cont_fetch_timeout", 32'd1, 32'd0); end
            end
            i_fetch_req = 1'b0;
         end
      join
      idle_gap(1);
      chk("cont_order_drained", exp_order.size(), 0);
      chk("conflicts", {24'd0, o_conflicts}, exp_conf);
   endtask

   initial begin
      int k;
      bit got;
      logic [7:0] a;

      for (int i = 0; i < 256; i++) preload[i] = 8'($urandom);
      preload[4] = 8'hEF; preload[5] = 8'hBE; preload[6] = 8'hAD; preload[7] = 8'hDE;
      for (int i = 0; i < 256; i++) shadow[i] = preload[i];

      i_rst = 1'b1; mem_init = 1'b1;
      i_fetch_req = 1'b0; i_fetch_addr = 8'd0; i_prog_mode = 1'b0;
      i_prog_req = 1'b0; i_prog_we = 1'b0; i_prog_addr = 8'd0; i_prog_wdata = 8'd0;
      repeat (2) @(negedge i_clk);
      chk("rst_busy", {31'd0, o_busy}, 32'd0);
      chk("rst_conflicts", {24'd0, o_conflicts}, 32'd0);
      chk("rst_mem_en", {31'd0, o_mem_en}, 32'd0);
      chk("rst_mem_we", {31'd0, o_mem_we}, 32'd0);
      chk("rst_acks", {30'd0, o_fetch_ack, o_prog_ack}, 32'd0);
      mem_init = 1'b0;
      i_rst = 1'b0;

      fetch_op(8'h04, 0);
      idle_gap(0);
      prog_op(1'b1, 8'h07, 8'hA5);
      idle_gap(0);
      fetch_op(8'h05, 0);
      idle_gap(0);

      for (int n = 0; n < 40; n++) begin
         a = 8'($urandom);
         case ($urandom_range(0, 3))
            0: fetch_op(a, $urandom_range(0, 2));
            1: prog_op(1'b1, a, 8'($urandom));
            2: prog_op(1'b0, a, 8'($urandom));
            default: fetch_op(a, 0);
         endcase
         idle_gap($urandom_range(0, 2));
      end

      // Fetch held while programming mode blocks it.
      a = 8'($urandom);
      exp_fetch.push_back(sh_word(a));
      push_mem(a, 1'b0, 4'b0000, 32'd0, 1'b0);
      exp_order.push_back(1'b0);
      m_last_prog = 1'b0;
      i_prog_mode = 1'b1; i_fetch_addr = a; i_fetch_req = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge i_clk);
         chk("blocked_busy", {31'd0, o_busy}, 32'd0);
         chk("blocked_ack", {31'd0, o_fetch_ack}, 32'd0);
      end
      i_prog_mode = 1'b0;
      k = 0; got = 1'b0;
      while (k < 3 && !got) begin
         @(negedge i_clk); k++;
         if (o_fetch_ack) got = 1'b1;
      end
      i_fetch_req = 1'b0;
      chk("unblock_ack", {31'd0, got}, 32'd1);
      idle_gap(0);
      chk("conflicts_none", {24'd0, o_conflicts}, exp_conf);

      contention(4, 2);

      // Reset pulsed during the ACCESS cycle of a write.
      a = 8'($urandom);
      push_mem(a, 1'b1, 4'b0001 << a[1:0], {4{8'h3C}}, 1'b1);
      i_prog_addr = a; i_prog_we = 1'b1; i_prog_wdata = 8'h3C; i_prog_req = 1'b1;
      @(negedge i_clk);
      #2 i_rst = 1'b1;
      #1;
      chk("rstmid_mem_we", {31'd0, o_mem_we}, 32'd0);
      chk("rstmid_mem_en", {31'd0, o_mem_en}, 32'd0);
      chk("rstmid_busy", {31'd0, o_busy}, 32'd0);
      chk("rstmid_conflicts", {24'd0, o_conflicts}, 32'd0);
      chk("rstmid_ack", {31'd0, o_prog_ack}, 32'd0);
      i_prog_req = 1'b0;
      exp_conf = 0;
      m_last_prog = 1'b0;
      @(negedge i_clk);
      i_rst = 1'b0;
      prog_op(1'b0, a, 8'd0);
      idle_gap(0);

      contention(300, 300);
      chk("conflicts_sat", {24'd0, o_conflicts}, 32'd255);
      chk("queues_drained", exp_fetch.size() + exp_prog.size() + exp_mem.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
